// File: rtl/fetch_queue.sv
// Instruction fetch queue: a DEPTH-entry FIFO between a synchronous IMEM
// (one request in flight) and a valid/ready decode stage. Redirects flush the
// queue and kill the outstanding read.
// Optional macro FETCH_BOUNDS_CHECK_EN: per-entry error bit for pc >= IMEM_WORDS.
module fetch_queue #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned INSTR_W    = 32,
    parameter int unsigned DEPTH      = 4,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1),
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_redirect_valid,
    input  logic [ADDR_W-1:0]  i_redirect_addr,
    input  logic               i_irq_valid,
    input  logic [ADDR_W-1:0]  i_irq_addr,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [INSTR_W-1:0] o_out_instr,
    output logic [ADDR_W-1:0]  o_out_pc,
    output logic [ADDR_W-1:0]  o_out_pc_plus,
    output logic               o_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic               r_inflight;
    logic [ADDR_W-1:0]  r_inflight_pc;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];

    logic w_flush;
    logic w_credit;
    logic w_issue;
    logic w_push;
    logic w_pop;
    logic w_valid;

    // Credit counts the in-flight read so its return can never overflow the queue
    always_comb begin
        w_flush  = i_irq_valid | i_redirect_valid;
        w_credit = ({1'b0, r_count} + (CNT_W + 1)'(r_inflight)) < (CNT_W + 1)'(DEPTH);
        w_issue  = !w_flush && w_credit;
        w_push   = r_inflight && !w_flush;
        w_valid  = (r_count != '0);
        w_pop    = w_valid && i_out_ready;
    end

    // IMEM request; held low while reset is asserted
    always_comb begin
        o_imem_req  = w_issue && i_rst_n;
        o_imem_addr = r_fetch_pc;
    end

    // Fetch PC, in-flight tracking, queue pointers and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (w_flush) begin
            // irq has priority over a branch redirect
            r_fetch_pc <= i_irq_valid ? i_irq_addr : i_redirect_addr;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc    <= r_fetch_pc + PC_STEP;
                r_inflight_pc <= r_fetch_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Queue payload storage; contents are only observed through a valid head
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= i_imem_rdata;
            r_pc_mem[r_wr_ptr]    <= r_inflight_pc;
        end
    end

    // Head outputs; forced to zero when empty so reset shows a clean head
    always_comb begin
        o_out_valid   = w_valid;
        o_out_instr   = w_valid ? r_instr_mem[r_rd_ptr] : '0;
        o_out_pc      = w_valid ? r_pc_mem[r_rd_ptr] : '0;
        o_out_pc_plus = o_out_pc + PC_STEP;
    end

`ifdef FETCH_BOUNDS_CHECK_EN
    logic r_err_mem [DEPTH];
    logic w_oob;

    // Out-of-range fetch is still queued, just tagged
    always_comb begin
        w_oob = (64'(r_inflight_pc) >= 64'(IMEM_WORDS));
        o_err = w_valid && r_err_mem[r_rd_ptr];
    end

    // Per-entry error bit written alongside the payload
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_err_mem[r_wr_ptr] <= w_oob;
        end
    end
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: cycle table plus reset and PC-wrap sequences.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        irq_valid;
    logic [31:0] irq_addr;
    logic        out_ready;

    logic        imem_req, out_valid, err;
    logic [31:0] imem_addr, imem_rdata, out_instr, out_pc, out_pc_plus;

    logic        w_imem_req, w_out_valid, w_err;
    logic [31:0] w_imem_addr, w_imem_rdata, w_out_instr, w_out_pc, w_out_pc_plus;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Synchronous IMEM models: data appears the cycle after the address
    always @(posedge clk) imem_rdata   <= imem_word(imem_addr);
    always @(posedge clk) w_imem_rdata <= imem_word(w_imem_addr);

    fetch_queue #(.IMEM_WORDS(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_redirect_valid(redirect_valid), .i_redirect_addr(redirect_addr),
        .i_irq_valid(irq_valid), .i_irq_addr(irq_addr),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_instr(out_instr),
        .o_out_pc(out_pc), .o_out_pc_plus(out_pc_plus), .o_err(err)
    );

    fetch_queue #(.RESET_PC(32'hFFFF_FFFE)) u_wrap (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_redirect_valid(1'b0), .i_redirect_addr(32'h0),
        .i_irq_valid(1'b0), .i_irq_addr(32'h0),
        .o_imem_req(w_imem_req), .o_imem_addr(w_imem_addr), .i_imem_rdata(w_imem_rdata),
        .o_out_valid(w_out_valid), .i_out_ready(1'b1), .o_out_instr(w_out_instr),
        .o_out_pc(w_out_pc), .o_out_pc_plus(w_out_pc_plus), .o_err(w_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic exp_err(input logic valid, input logic [31:0] pc);
`ifdef FETCH_BOUNDS_CHECK_EN
        return valid && (pc >= 32'd16);
`else
        return 1'b0;
`endif
    endfunction

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] ra;
        logic        iv;
        logic [31:0] ia;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 36;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] ra,
                                input logic iv, input logic [31:0] ia, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_pc);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.ra = ra; v.iv = iv; v.ia = ia;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    initial begin
        // streaming from reset, 1 instr/cycle
        tbl[0]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 1, 2, 1, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 1, 3, 1, 1);
        // decode stalls: queue fills, requests stop, head held
        tbl[4]  = mk(0, 0, 0, 0, 0, 1, 4, 1, 2);
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, 5, 1, 2);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 6, 1, 2);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 6, 1, 2);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 6, 1, 2);
        // drain without gap or duplicate
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 6, 1, 2);
        tbl[10] = mk(1, 0, 0, 0, 0, 1, 6, 1, 3);
        tbl[11] = mk(1, 0, 0, 0, 0, 1, 7, 1, 4);
        tbl[12] = mk(1, 0, 0, 0, 0, 1, 8, 1, 5);
        tbl[13] = mk(1, 0, 0, 0, 0, 1, 9, 1, 6);
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 10, 1, 7);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 11, 1, 7);
        tbl[16] = mk(1, 0, 0, 0, 0, 0, 11, 1, 7);
        tbl[17] = mk(0, 0, 0, 0, 0, 1, 11, 1, 8);
        // redirect with 8..10 queued and 11 in flight
        tbl[18] = mk(1, 1, 32'h40, 0, 0, 0, 12, 1, 8);
        tbl[19] = mk(1, 0, 0, 0, 0, 1, 32'h40, 0, 0);
        tbl[20] = mk(1, 0, 0, 0, 0, 1, 32'h41, 0, 0);
        tbl[21] = mk(1, 0, 0, 0, 0, 1, 32'h42, 1, 32'h40);
        // irq beats redirect
        tbl[22] = mk(1, 1, 32'h40, 1, 32'h100, 0, 32'h43, 1, 32'h41);
        tbl[23] = mk(1, 0, 0, 0, 0, 1, 32'h100, 0, 0);
        tbl[24] = mk(1, 0, 0, 0, 0, 1, 32'h101, 0, 0);
        tbl[25] = mk(1, 0, 0, 0, 0, 1, 32'h102, 1, 32'h100);
        // redirect held two cycles: last target wins
        tbl[26] = mk(1, 1, 32'h200, 0, 0, 0, 32'h103, 1, 32'h101);
        tbl[27] = mk(1, 1, 32'h300, 0, 0, 0, 32'h200, 0, 0);
        tbl[28] = mk(1, 0, 0, 0, 0, 1, 32'h300, 0, 0);
        tbl[29] = mk(1, 0, 0, 0, 0, 1, 32'h301, 0, 0);
        tbl[30] = mk(1, 0, 0, 0, 0, 1, 32'h302, 1, 32'h300);
        // bounds edge: pc 15 in range, 16 out of range
        tbl[31] = mk(1, 1, 15, 0, 0, 0, 32'h303, 1, 32'h301);
        tbl[32] = mk(1, 0, 0, 0, 0, 1, 15, 0, 0);
        tbl[33] = mk(1, 0, 0, 0, 0, 1, 16, 0, 0);
        tbl[34] = mk(1, 0, 0, 0, 0, 1, 17, 1, 15);
        tbl[35] = mk(1, 0, 0, 0, 0, 1, 18, 1, 16);

        rst_n = 1'b0;
        redirect_valid = 1'b0; redirect_addr = '0;
        irq_valid = 1'b0; irq_addr = '0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        #2;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset imem_req", {31'b0, imem_req}, 32'd0);
        check("reset err", {31'b0, err}, 32'd0);
        check("reset out_pc", out_pc, 32'd0);
        check("reset out_instr", out_instr, 32'd0);
        check("reset out_pc_plus", out_pc_plus, 32'd1);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            out_ready = tbl[i].rdy;
            redirect_valid = tbl[i].rv; redirect_addr = tbl[i].ra;
            irq_valid = tbl[i].iv; irq_addr = tbl[i].ia;
            #2;
            check($sformatf("c%0d imem_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
            check($sformatf("c%0d imem_addr", i), imem_addr, tbl[i].e_addr);
            check($sformatf("c%0d out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_valid});
            check($sformatf("c%0d err", i), {31'b0, err},
                  {31'b0, exp_err(tbl[i].e_valid, tbl[i].e_pc)});
            if (tbl[i].e_valid) begin
                check($sformatf("c%0d out_pc", i), out_pc, tbl[i].e_pc);
                check($sformatf("c%0d out_instr", i), out_instr, imem_word(tbl[i].e_pc));
                check($sformatf("c%0d out_pc_plus", i), out_pc_plus, tbl[i].e_pc + 32'd1);
            end
            @(negedge clk);
        end

        // Reset mid-stream: head must vanish without waiting for a clock
        out_ready = 1'b1; redirect_valid = 1'b0; irq_valid = 1'b0;
        #3;
        check("pre-reset out_valid", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid-reset out_valid", {31'b0, out_valid}, 32'd0);
        check("mid-reset imem_req", {31'b0, imem_req}, 32'd0);
        check("mid-reset wrap out_valid", {31'b0, w_out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            check($sformatf("restart c%0d imem_addr", c), imem_addr, 32'(c));
            check($sformatf("restart c%0d imem_req", c), {31'b0, imem_req}, 32'd1);
            check($sformatf("restart c%0d out_valid", c), {31'b0, out_valid},
                  (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                check($sformatf("restart c%0d out_pc", c), out_pc, 32'(c - 2));
                check($sformatf("restart c%0d out_pc_plus", c), out_pc_plus, 32'(c - 1));
            end
            // PC wrap instance starts at FFFFFFFE
            check($sformatf("wrap c%0d imem_addr", c), w_imem_addr, 32'hFFFF_FFFE + 32'(c));
            check($sformatf("wrap c%0d out_valid", c), {31'b0, w_out_valid},
                  (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                check($sformatf("wrap c%0d out_pc", c), w_out_pc, 32'hFFFF_FFFC + 32'(c));
                check($sformatf("wrap c%0d out_instr", c), w_out_instr,
                      imem_word(32'hFFFF_FFFC + 32'(c)));
                check($sformatf("wrap c%0d out_pc_plus", c), w_out_pc_plus,
                      32'hFFFF_FFFD + 32'(c));
                check($sformatf("wrap c%0d err", c), {31'b0, w_err}, 32'd0);
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
